// File: rtl/dvi_timing_ctrl.sv
// dvi_timing_ctrl: programmable DVI/TMDS video timing generator (de, hsync, vsync, x, y).
// Latency: one pix_clk from counter (h,v) to every registered output.
// Config: staging registers are copied to the active set only at a frame wrap (or at once when idle).
//
// Ports:
//   pix_clk, rst_n          clock / async active-low reset
//   run                     level, 1 = generate frames (start/stop honoured at frame boundaries)
//   cfg_wr/addr/wdata       staging write: 0..7 timing fields, 8 = polarity {vsync,hsync}, 9..15 ignored
//   cfg_commit              request staging->active transfer; cfg_busy while pending, cfg_err on reject
//   de, hsync, vsync, x, y  decoded video timing
//   line_start, frame_start one-cycle pulses at h==0 / (h,v)==(0,0)
//   active                  1 while in RUN or STOPPING
module dvi_timing_ctrl #(
  parameter int CW           = 13,
  parameter int DEF_H_ACTIVE = 640,
  parameter int DEF_H_FP     = 16,
  parameter int DEF_H_SYNC   = 96,
  parameter int DEF_H_BP     = 48,
  parameter int DEF_V_ACTIVE = 480,
  parameter int DEF_V_FP     = 10,
  parameter int DEF_V_SYNC   = 2,
  parameter int DEF_V_BP     = 33
) (
  input  logic          pix_clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          cfg_wr,
  input  logic [3:0]    cfg_addr,
  input  logic [CW-1:0] cfg_wdata,
  input  logic          cfg_commit,
  output logic          cfg_busy,
  output logic          cfg_err,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          active
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  localparam logic [CW+1:0] MAX_TOTAL = {2'b00, {CW{1'b1}}};

  function automatic logic [CW-1:0] def_field(input int idx);
    case (idx)
      0:       return CW'(DEF_H_ACTIVE);
      1:       return CW'(DEF_H_FP);
      2:       return CW'(DEF_H_SYNC);
      3:       return CW'(DEF_H_BP);
      4:       return CW'(DEF_V_ACTIVE);
      5:       return CW'(DEF_V_FP);
      6:       return CW'(DEF_V_SYNC);
      default: return CW'(DEF_V_BP);
    endcase
  endfunction

  state_t        state;
  logic [CW-1:0] h, v;
  logic [CW-1:0] stg [8];
  logic [CW-1:0] act [8];
  logic [1:0]    stg_pol, act_pol;
  logic          pending;

  // Boundaries of the active set; a validated set always fits in CW bits.
  logic [CW-1:0] hs_beg, hs_end, ht, vs_beg, vs_end, vt;
  assign hs_beg = act[0] + act[1];
  assign hs_end = hs_beg + act[2];
  assign ht     = hs_end + act[3];
  assign vs_beg = act[4] + act[5];
  assign vs_end = vs_beg + act[6];
  assign vt     = vs_end + act[7];

  // Staging totals are widened so an overflowing set is detected rather than wrapped.
  logic [CW+1:0] stg_ht, stg_vt;
  assign stg_ht = {2'b00, stg[0]} + {2'b00, stg[1]} + {2'b00, stg[2]} + {2'b00, stg[3]};
  assign stg_vt = {2'b00, stg[4]} + {2'b00, stg[5]} + {2'b00, stg[6]} + {2'b00, stg[7]};

  logic stg_bad;
  assign stg_bad = (stg[0] == '0) || (stg[2] == '0) || (stg[4] == '0) || (stg[6] == '0) ||
                   (stg_ht > MAX_TOTAL) || (stg_vt > MAX_TOTAL);

  logic running, h_last, v_last, wrap, copy, h_on, v_on;
  assign running = (state != IDLE);
  assign h_last  = (h == ht - CW'(1));
  assign v_last  = (v == vt - CW'(1));
  assign wrap    = running && h_last && v_last;
  assign copy    = pending && (wrap || state == IDLE);
  assign h_on    = running && (h >= hs_beg) && (h < hs_end);
  assign v_on    = running && (v >= vs_beg) && (v < vs_end);

  assign cfg_busy = pending;

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      active      <= 1'b0;
      h           <= '0;
      v           <= '0;
      for (int i = 0; i < 8; i++) begin
        stg[i] <= def_field(i);
        act[i] <= def_field(i);
      end
      stg_pol     <= 2'b11;
      act_pol     <= 2'b11;
      pending     <= 1'b0;
      cfg_err     <= 1'b0;
      de          <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // Control FSM; active mirrors the next state so it is a plain flop.
      case (state)
        IDLE: if (run) begin
          state  <= RUN;
          active <= 1'b1;
        end
        RUN: if (!run) state <= STOPPING;
        STOPPING: begin
          if (run) begin
            state <= RUN;
          end else if (wrap) begin
            state  <= IDLE;
            active <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          active <= 1'b0;
        end
      endcase

      // Counters sit at (0,0) while idle so the first frame starts cleanly.
      if (!running) begin
        h <= '0;
        v <= '0;
      end else if (h_last) begin
        h <= '0;
        v <= v_last ? '0 : v + CW'(1);
      end else begin
        h <= h + CW'(1);
      end

      if (cfg_wr) begin
        if (cfg_addr < 4'd8)       stg[cfg_addr[2:0]] <= cfg_wdata;
        else if (cfg_addr == 4'd8) stg_pol            <= cfg_wdata[1:0];
      end

      // The copy sees pre-edge staging values; a same-cycle write lands afterwards.
      if (copy && !stg_bad) begin
        for (int i = 0; i < 8; i++) act[i] <= stg[i];
        act_pol <= stg_pol;
      end
      pending <= copy ? 1'b0 : (pending | cfg_commit);
      cfg_err <= copy && stg_bad;

      // Sync level: asserted drives the polarity bit, deasserted its inverse.
      de          <= running && (h < act[0]) && (v < act[4]);
      hsync       <= ~(h_on ^ act_pol[0]);
      vsync       <= ~(v_on ^ act_pol[1]);
      x           <= running ? h : '0;
      y           <= running ? v : '0;
      line_start  <= running && (h == '0);
      frame_start <= running && (h == '0) && (v == '0);
    end
  end

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
module tb_dvi_timing_ctrl;

  localparam int CW  = 13;
  localparam int LIM = 5000;
  // Small defaults (HT=24, VT=10) keep default-timing frames short.
  localparam int DEFS [8] = '{16, 2, 4, 2, 6, 1, 1, 2};
  localparam int NEWT [8] = '{100, 4, 8, 8, 10, 1, 1, 2};

  logic          pix_clk = 1'b0;
  logic          rst_n   = 1'b0;
  logic          run     = 1'b0;
  logic          cfg_wr  = 1'b0;
  logic [3:0]    cfg_addr = '0;
  logic [CW-1:0] cfg_wdata = '0;
  logic          cfg_commit = 1'b0;
  logic          cfg_busy, cfg_err, de, hsync, vsync, line_start, frame_start, active;
  logic [CW-1:0] x, y;

  int n_chk = 0;
  int n_err = 0;

  always #5 pix_clk = ~pix_clk;

  dvi_timing_ctrl #(
    .CW(CW),
    .DEF_H_ACTIVE(16), .DEF_H_FP(2), .DEF_H_SYNC(4), .DEF_H_BP(2),
    .DEF_V_ACTIVE(6),  .DEF_V_FP(1), .DEF_V_SYNC(1), .DEF_V_BP(2)
  ) dut (
    .pix_clk(pix_clk), .rst_n(rst_n), .run(run),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit),
    .cfg_busy(cfg_busy), .cfg_err(cfg_err),
    .de(de), .hsync(hsync), .vsync(vsync), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start), .active(active)
  );

  logic [33:0] dut_vec;
  assign dut_vec = {active, cfg_busy, cfg_err, frame_start, line_start, de, hsync, vsync, x, y};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: on each edge it pushes the outputs the DUT must show after that edge.
  logic [33:0] sb_q [$];
  int m_state, m_h, m_v, mpol, spol;
  bit m_pend;
  int ma [8];
  int ms [8];

  always @(posedge pix_clk or negedge rst_n) begin
    int ht, vt, ns, sht, svt, nh, nv;
    bit runn, hon, von, wrap, cpy, bad, npend, e_hs, e_vs, e_de;
    if (!rst_n) begin
      m_state = 0; m_h = 0; m_v = 0; m_pend = 0; mpol = 3; spol = 3;
      for (int i = 0; i < 8; i++) begin ma[i] = DEFS[i]; ms[i] = DEFS[i]; end
      sb_q.delete();
    end else begin
      ht   = ma[0] + ma[1] + ma[2] + ma[3];
      vt   = ma[4] + ma[5] + ma[6] + ma[7];
      runn = (m_state != 0);
      hon  = runn && (m_h >= ma[0] + ma[1]) && (m_h < ma[0] + ma[1] + ma[2]);
      von  = runn && (m_v >= ma[4] + ma[5]) && (m_v < ma[4] + ma[5] + ma[6]);
      e_de = runn && (m_h < ma[0]) && (m_v < ma[4]);
      e_hs = hon ? mpol[0] : !mpol[0];
      e_vs = von ? mpol[1] : !mpol[1];
      wrap = runn && (m_h == ht - 1) && (m_v == vt - 1);
      ns = m_state;
      case (m_state)
        0: if (run) ns = 1;
        1: if (!run) ns = 2;
        default: if (run) ns = 1; else if (wrap) ns = 0;
      endcase
      cpy   = m_pend && (wrap || m_state == 0);
      sht   = ms[0] + ms[1] + ms[2] + ms[3];
      svt   = ms[4] + ms[5] + ms[6] + ms[7];
      bad   = (ms[0] == 0) || (ms[2] == 0) || (ms[4] == 0) || (ms[6] == 0) ||
              (sht > 8191) || (svt > 8191);
      npend = cpy ? 1'b0 : (m_pend | cfg_commit);
      sb_q.push_back({(ns != 0), npend, (cpy && bad), (runn && m_h == 0 && m_v == 0),
                      (runn && m_h == 0), e_de, e_hs, e_vs,
                      13'(runn ? m_h : 0), 13'(runn ? m_v : 0)});
      if (!runn) begin nh = 0; nv = 0; end
      else if (m_h == ht - 1) begin nh = 0; nv = (m_v == vt - 1) ? 0 : m_v + 1; end
      else begin nh = m_h + 1; nv = m_v; end
      if (cpy && !bad) begin
        for (int i = 0; i < 8; i++) ma[i] = ms[i];
        mpol = spol;
      end
      if (cfg_wr) begin
        if (cfg_addr < 8) ms[cfg_addr] = int'(cfg_wdata);
        else if (cfg_addr == 8) spol = int'(cfg_wdata[1:0]);
      end
      m_h = nh; m_v = nv; m_state = ns; m_pend = npend;
    end
  end

  always @(negedge pix_clk) begin
    if (!rst_n) chk("reset_outputs", dut_vec, '0);
    else if (sb_q.size() == 0) chk("sb_underflow", sb_q.size(), 1);
    else chk("cycle_outputs", dut_vec, sb_q.pop_front());
  end

  // Stimulus helpers, called at a falling edge and returning at the next one.
  task automatic wr(input int a, input int d);
    cfg_wr = 1'b1; cfg_addr = 4'(a); cfg_wdata = CW'(d);
    @(negedge pix_clk);
    cfg_wr = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    @(negedge pix_clk);
    cfg_commit = 1'b0;
  endtask

  task automatic wait_xy(input int wx, input int wy, input string tag);
    int k = 0;
    while (!(x == CW'(wx) && y == CW'(wy) && active) && k < LIM) begin
      @(negedge pix_clk); k++;
    end
    chk(tag, (k < LIM), 1);
  endtask

  // Measures one full frame from a frame_start to the next.
  task automatic meas(input string tag, input int e_per, input int e_de, input int e_hs, input int e_vs);
    int k = 0;
    int per = 0, nde = 0, nhs = 0, nvs = 0;
    while (!frame_start && k < LIM) begin @(negedge pix_clk); k++; end
    chk({tag, "_fs_seen"}, (k < LIM), 1);
    do begin
      nde += int'(de); nhs += int'(hsync); nvs += int'(vsync); per++;
      @(negedge pix_clk);
    end while (!frame_start && per < LIM);
    chk({tag, "_period"}, per, e_per);
    chk({tag, "_de_cycles"}, nde, e_de);
    chk({tag, "_hsync_hi"}, nhs, e_hs);
    chk({tag, "_vsync_hi"}, nvs, e_vs);
  endtask

  initial begin
    int k;
    // 1: reset, then run with defaults
    repeat (3) @(negedge pix_clk);
    chk("reset_state", dut_vec, '0);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge pix_clk);
    run = 1'b1;
    meas("def", 240, 96, 40, 24);

    // 2: stage new timing mid-frame, plus an ignored write, then commit
    wait_xy(3, 3, "wait_mid_def");
    for (int i = 0; i < 8; i++) wr(i, NEWT[i]);
    wr(12, 0);
    commit();
    chk("busy_rise", cfg_busy, 1);
    meas("new", 1680, 1000, 112, 120);
    chk("busy_fell", cfg_busy, 0);

    // 3: both syncs active-low
    wr(8, 0);
    commit();
    k = 0;
    while (cfg_busy && k < LIM) begin @(negedge pix_clk); k++; end
    chk("pol_commit_done", (k < LIM), 1);
    meas("lowpol", 1680, 1000, 1568, 1560);

    // 4: rejected commit (V_SYNC=0)
    wr(6, 0);
    commit();
    k = 0;
    while (cfg_busy && k < LIM) begin @(negedge pix_clk); k++; end
    chk("rej_busy_clear", (k < LIM), 1);
    chk("rej_err_pulse", cfg_err, 1);
    @(negedge pix_clk);
    chk("rej_err_once", cfg_err, 0);
    meas("rej", 1680, 1000, 1568, 1560);

    // 5: stop at y=5 with a simultaneous commit restoring active-high syncs
    wr(6, 1);
    wr(8, 3);
    wait_xy(0, 5, "wait_y5");
    run = 1'b0; cfg_commit = 1'b1;
    @(negedge pix_clk);
    cfg_commit = 1'b0;
    k = 0;
    while (active && k < LIM) begin @(negedge pix_clk); k++; end
    chk("stop_reached_idle", (k < LIM), 1);
    chk("stop_commit_applied", cfg_busy, 0);
    chk("idle_de", de, 0);
    repeat (6) @(negedge pix_clk);
    run = 1'b1;
    meas("restart", 1680, 1000, 112, 120);
    wait_xy(0, 5, "wait_y5_again");
    run = 1'b0;
    wait_xy(0, 8, "wait_y8_stopping");
    run = 1'b1;
    meas("resume", 1680, 1000, 112, 120);

    // 6: asynchronous reset inside the active area
    k = 0;
    while (!de && k < LIM) begin @(negedge pix_clk); k++; end
    chk("de_seen_before_rst", (k < LIM), 1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", dut_vec, '0);
    @(negedge pix_clk);
    @(negedge pix_clk);
    #1 rst_n = 1'b1;
    k = 0;
    while (!frame_start && k < LIM) begin @(negedge pix_clk); k++; end
    chk("fs_after_rst", k, 2);
    meas("post_rst", 240, 96, 40, 24);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dvi_timing_ctrl.md
# dvi_timing_ctrl

Programmable video timing controller for the DVI/TMDS transmit path. It sequences the per-channel TMDS encoders by generating data-enable, hSync, vSync and pixel coordinates in the pixel clock domain. Timing fields are written through a staging register set and take effect only at a frame boundary, so the sink never sees a torn frame. Start and stop requests are also applied only at frame boundaries.

## Interface
Parameters:
- CW, 13, width of counters, coordinates and timing fields
- DEF_H_ACTIVE / DEF_H_FP / DEF_H_SYNC / DEF_H_BP, 640 / 16 / 96 / 48, horizontal reset defaults (total 800)
- DEF_V_ACTIVE / DEF_V_FP / DEF_V_SYNC / DEF_V_BP, 480 / 10 / 2 / 33, vertical reset defaults (total 525)

Ports:
- pix_clk  in  1  pixel clock, sole clock
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  level; 1 = generate frames
- cfg_wr  in  1  staging-register write strobe
- cfg_addr  in  4  0..7 = H_ACTIVE, H_FP, H_SYNC, H_BP, V_ACTIVE, V_FP, V_SYNC, V_BP; 8 = polarity (bit0 hsync, bit1 vsync; 1 = active-high)
- cfg_wdata  in  CW  write data
- cfg_commit  in  1  one-cycle pulse requesting staging→active transfer
- cfg_busy  out  1  commit pending
- cfg_err  out  1  one-cycle pulse: commit rejected
- de  out  1  draw area
- hsync, vsync  out  1 each  syncs at programmed polarity
- x, y  out  CW each  coordinates aligned with de
- line_start, frame_start  out  1 each  one-cycle pulses
- active  out  1  1 while in RUN or STOPPING

## Operation
- States: IDLE, RUN, STOPPING.
- IDLE → RUN when run=1. Counters are held at (0,0) in IDLE, so the first outputs correspond to h=0, v=0.
- RUN → STOPPING when run=0.
- STOPPING → RUN when run=1 again. There is no discontinuity in the counters.
- STOPPING → IDLE at frame wrap.
- Counters:
  - h runs 0..HT-1, where HT = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - At h=HT-1, h wraps to 0 and v increments.
  - At v=VT-1 together with h=HT-1, v wraps to 0. This is the "frame wrap".
- Decode from counters (h,v):
  - de = h<H_ACTIVE && v<V_ACTIVE
  - hsync asserted for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC
  - vsync asserted for V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC (whole lines)
  - line_start = (h==0)
  - frame_start = (h==0 && v==0)
  - x=h, y=v
- Polarity: an active-high field drives 1 when asserted, 0 otherwise. An active-low field is the inverse.
- In IDLE: de=0, line_start=0, frame_start=0, syncs at their inactive level, x=y=0.
- Staging registers:
  - cfg_wr writes staging at any time, including while cfg_busy=1.
  - Writes to addr 9..15 are ignored.
- Commit:
  - cfg_commit sets pending (cfg_busy=1).
  - The staging→active copy happens in the cycle of frame wrap, or in the next cycle if state is IDLE. pending then clears.
  - The staging contents at the moment of the copy are used.
  - A commit while pending is already set is absorbed; there is no error.
- Validation at copy time:
  - Reject if any of H_ACTIVE, H_SYNC, V_ACTIVE, V_SYNC is 0, or if HT or VT exceeds 2^CW−1. Sums are computed at CW+2 bits.
  - On reject: active registers unchanged, pending cleared, cfg_err pulses for 1 cycle.
- Reset: active and staging registers load the DEF_* values and polarity 2'b11. State IDLE, pending 0, counters 0.

## Timing
- All outputs are registered. Each output reflects the counter value of the previous cycle, i.e. one cycle of latency from (h,v) to de/sync/x/y.
- Reset values:
  - de, hsync, vsync, x, y, line_start, frame_start, cfg_busy, cfg_err, active = 0.
  - Sync outputs then follow the active polarity once the polarity register is valid.
- Start:
  - run sampled high at edge N → state RUN at N.
  - Counters start advancing after edge N.
  - frame_start=1, de=1 (if V_ACTIVE,H_ACTIVE>0), x=0 and y=0 in the cycle after edge N+1.
- Frame period is HT·VT cycles. frame_start recurs exactly every HT·VT cycles.
- New timing applies from the first (0,0) following the wrap where the copy happened.
- cfg_busy rises the cycle after cfg_commit and falls the cycle after the copy.
- rst_n asserted mid-frame: all outputs drop to their reset values asynchronously. No partial-frame completion.
- If run=0 and cfg_commit arrive in the same RUN cycle, the commit still applies at the stopping frame's wrap.

## Test plan
1. Reset, run=1, defaults:
   - frame_start period = 420000 cycles.
   - de high for 640 cycles per line on lines 0..479.
   - hsync high for x=656..751; vsync high on y=490..491.
2. Write H_ACTIVE=100, H_FP=4, H_SYNC=8, H_BP=8, V_ACTIVE=10, V_FP=1, V_SYNC=1, V_BP=2, then commit mid-frame:
   - Current frame completes with 800×525 timing.
   - Next frame: HT=120, VT=14; cfg_busy falls at that wrap.
3. Write polarity=0 (both active-low) with the step 2 fields, then commit:
   - hsync low only for x=104..111; vsync low only on y=11.
   - Both high elsewhere, including in IDLE.
4. Commit with V_SYNC=0:
   - cfg_err pulses once at the wrap, cfg_busy clears, timing unchanged.
5. Deassert run at y=5:
   - Frame finishes, state goes IDLE with active=0, de stays 0.
   - Reassert run during STOPPING: frames continue back-to-back with no gap.
6. Assert rst_n=0 in the middle of the active area:
   - All outputs 0 immediately.
   - After release with run=1, first frame_start occurs 2 cycles later using default timing.
